// File: rtl/riscv.sv
// riscv: single-cycle RV32I subset core, CPI = 1.
// Ports: clk, rst (sync, active-high), inst_* fetch bus, data_* load/store bus.
module riscv #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] inst_addr_o,
  input  logic [31:0] inst_i,
  output logic        inst_ce_o,
  output logic        data_ce_o,
  output logic        data_we_o,
  output logic [31:0] data_addr_o,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  logic [31:0] r_pc;
  logic [31:0] r_x [32];

  logic [6:0]  w_op;
  logic [6:0]  w_f7;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [2:0]  w_f3;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [31:0] w_ob;
  logic [4:0]  w_sh;
  logic [31:0] w_alu;
  logic        w_take;
  logic        w_alt;
  logic        w_lui;
  logic        w_auipc;
  logic        w_jal;
  logic        w_jalr;
  logic        w_br;
  logic        w_lw;
  logic        w_sw;
  logic        w_opi;
  logic        w_opr;
  logic        w_mem;
  logic        w_wen;
  logic [31:0] w_wd;
  logic [31:0] w_npc;

  assign w_op  = inst_i[6:0];
  assign w_rd  = inst_i[11:7];
  assign w_f3  = inst_i[14:12];
  assign w_rs1 = inst_i[19:15];
  assign w_rs2 = inst_i[24:20];
  assign w_f7  = inst_i[31:25];

  assign w_imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
  assign w_imm_s = {{20{inst_i[31]}}, inst_i[31:25],
                    inst_i[11:7]};
  assign w_imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                    inst_i[30:25], inst_i[11:8], 1'b0};
  assign w_imm_u = {inst_i[31:12], 12'h000};
  assign w_imm_j = {{11{inst_i[31]}}, inst_i[31],
                    inst_i[19:12], inst_i[20],
                    inst_i[30:21], 1'b0};

  assign w_a = (w_rs1 == 5'd0) ? 32'd0 : r_x[w_rs1];
  assign w_b = (w_rs2 == 5'd0) ? 32'd0 : r_x[w_rs2];

  // Anything outside the legal encodings leaves every flag low -> NOP.
  assign w_lui   = (w_op == 7'b0110111);
  assign w_auipc = (w_op == 7'b0010111);
  assign w_jal   = (w_op == 7'b1101111);
  assign w_jalr  = (w_op == 7'b1100111) && (w_f3 == 3'b000);
  assign w_br    = (w_op == 7'b1100011) && (w_f3[2:1] != 2'b01);
  assign w_lw    = (w_op == 7'b0000011) && (w_f3 == 3'b010);
  assign w_sw    = (w_op == 7'b0100011) && (w_f3 == 3'b010);
  assign w_opi   = (w_op == 7'b0010011) &&
                   ((w_f3[1:0] != 2'b01) || (w_f7 == 7'h00) ||
                    (w_f3[2] && (w_f7 == 7'h20)));
  assign w_opr   = (w_op == 7'b0110011) &&
                   ((w_f7 == 7'h00) ||
                    ((w_f7 == 7'h20) &&
                     ((w_f3 == 3'b000) || (w_f3 == 3'b101))));

  // funct7[5] selects SUB/SRA; for immediates only SRAI carries it.
  assign w_alt = w_f7[5] && (w_opr || (w_f3 == 3'b101));
  assign w_ob  = w_opr ? w_b : w_imm_i;
  assign w_sh  = w_ob[4:0];

  always_comb begin
    w_alu = 32'd0;
    unique case (w_f3)
      3'b000: w_alu = w_alt ? w_a - w_ob : w_a + w_ob;
      3'b001: w_alu = w_a << w_sh;
      3'b010: w_alu = {31'd0, $signed(w_a) < $signed(w_ob)};
      3'b011: w_alu = {31'd0, w_a < w_ob};
      3'b100: w_alu = w_a ^ w_ob;
      3'b101: w_alu = w_alt ? 32'($signed(w_a) >>> w_sh)
                            : w_a >> w_sh;
      3'b110: w_alu = w_a | w_ob;
      3'b111: w_alu = w_a & w_ob;
      default: w_alu = 32'd0;
    endcase
  end

  always_comb begin
    w_take = 1'b0;
    case (w_f3)
      3'b000: w_take = (w_a == w_b);
      3'b001: w_take = (w_a != w_b);
      3'b100: w_take = $signed(w_a) < $signed(w_b);
      3'b101: w_take = $signed(w_a) >= $signed(w_b);
      3'b110: w_take = w_a < w_b;
      3'b111: w_take = w_a >= w_b;
      default: w_take = 1'b0;
    endcase
  end

  always_comb begin
    w_npc = r_pc + 32'd4;
    w_wen = 1'b0;
    w_wd  = 32'd0;
    unique case (1'b1)
      w_lui: begin
        w_wen = 1'b1;
        w_wd  = w_imm_u;
      end
      w_auipc: begin
        w_wen = 1'b1;
        w_wd  = r_pc + w_imm_u;
      end
      w_jal: begin
        w_wen = 1'b1;
        w_wd  = r_pc + 32'd4;
        w_npc = r_pc + w_imm_j;
      end
      w_jalr: begin
        w_wen = 1'b1;
        w_wd  = r_pc + 32'd4;
        w_npc = (w_a + w_imm_i) & ~32'd1;
      end
      w_br: begin
        if (w_take) w_npc = r_pc + w_imm_b;
      end
      w_lw: begin
        w_wen = 1'b1;
        w_wd  = data_i;
      end
      w_opi, w_opr: begin
        w_wen = 1'b1;
        w_wd  = w_alu;
      end
      default: ;
    endcase
  end

  // Reset suppresses every side effect of the instruction in flight.
  assign w_mem       = (w_lw || w_sw) && !rst;
  assign inst_addr_o = r_pc;
  assign inst_ce_o   = !rst;
  assign data_ce_o   = w_mem;
  assign data_we_o   = w_sw && !rst;
  assign data_addr_o = w_mem ? w_a + (w_sw ? w_imm_s : w_imm_i)
                             : 32'd0;
  assign data_o      = data_we_o ? w_b : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
      for (int i = 0; i < 32; i++) r_x[i] <= 32'd0;
    end else begin
      r_pc <= w_npc;
      if (w_wen && (w_rd != 5'd0)) r_x[w_rd] <= w_wd;
    end
  end

endmodule

// File: tb/tb_riscv.sv
// tb_riscv: directed programs plus random programs against an ISS model.
// Drives riscv with bench-side instruction and data memories.
module tb_riscv;

  logic        clk;
  logic        rst;
  logic [31:0] inst_addr_o;
  logic [31:0] inst_i;
  logic        inst_ce_o;
  logic        data_ce_o;
  logic        data_we_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_i;
  logic [31:0] data_o;

  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  logic [31:0] m_dm [64];
  logic [31:0] m_x  [32];
  logic [31:0] m_pc;
  logic [31:0] prog [$];
  int          n_chk;
  int          n_err;

  riscv dut (
    .clk(clk), .rst(rst),
    .inst_addr_o(inst_addr_o), .inst_i(inst_i),
    .inst_ce_o(inst_ce_o), .data_ce_o(data_ce_o),
    .data_we_o(data_we_o), .data_addr_o(data_addr_o),
    .data_i(data_i), .data_o(data_o)
  );

  assign inst_i = imem[inst_addr_o[7:2]];
  assign data_i = dmem[data_addr_o[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] e_i(
    logic [6:0] op, logic [2:0] f3, logic [4:0] rd,
    logic [4:0] rs1, logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] e_r(
    logic [6:0] f7, logic [2:0] f3, logic [4:0] rd,
    logic [4:0] rs1, logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] e_s(
    logic [4:0] rs2, logic [4:0] rs1, logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] e_b(
    logic [2:0] f3, logic [4:0] rs1, logic [4:0] rs2,
    logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3,
            imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] e_j(
    logic [4:0] rd, logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12],
            rd, 7'h6f};
  endfunction

  function automatic logic [31:0] alu(
    logic [2:0] f3, logic alt,
    logic [31:0] a, logic [31:0] b);
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? 32'($signed(a) >>> b[4:0])
                       : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic taken(
    logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Instruction-set model: one call = one architectural instruction.
  task automatic m_eval(
    output logic [31:0] npc, output logic wen,
    output logic [4:0] rd, output logic [31:0] wd,
    output logic ce, output logic we,
    output logic [31:0] ad, output logic [31:0] dq);
    logic [31:0] in, a, b, ii, si, bi, ji, ui;
    logic [6:0] op, f7;
    logic [2:0] f3;
    in = imem[m_pc[7:2]];
    op = in[6:0];
    f3 = in[14:12];
    f7 = in[31:25];
    rd = in[11:7];
    a  = m_x[in[19:15]];
    b  = m_x[in[24:20]];
    ii = 32'($signed(in[31:20]));
    si = 32'($signed({in[31:25], in[11:7]}));
    bi = 32'($signed({in[31], in[7], in[30:25],
                      in[11:8], 1'b0}));
    ji = 32'($signed({in[31], in[19:12], in[20],
                      in[30:21], 1'b0}));
    ui = {in[31:12], 12'h000};
    npc = m_pc + 4;
    wen = 0; wd = 0; ce = 0; we = 0; ad = 0; dq = 0;
    case (op)
      7'h37: begin wen = 1; wd = ui; end
      7'h17: begin wen = 1; wd = m_pc + ui; end
      7'h6f: begin
        wen = 1; wd = m_pc + 4; npc = m_pc + ji;
      end
      7'h67: if (f3 == 0) begin
        wen = 1; wd = m_pc + 4; npc = (a + ii) & ~32'd1;
      end
      7'h63: if (taken(f3, a, b)) npc = m_pc + bi;
      7'h03: if (f3 == 2) begin
        ce = 1; ad = a + ii; wen = 1; wd = m_dm[ad[7:2]];
      end
      7'h23: if (f3 == 2) begin
        ce = 1; we = 1; ad = a + si; dq = b;
      end
      7'h13: if ((f3 != 1 || f7 == 0) &&
                 (f3 != 5 || f7 == 0 || f7 == 7'h20)) begin
        wen = 1;
        wd = alu(f3, f3 == 5 && f7 == 7'h20, a, ii);
      end
      7'h33: if (f7 == 0 ||
                 (f7 == 7'h20 && (f3 == 0 || f3 == 5))) begin
        wen = 1;
        wd = alu(f3, f7 == 7'h20, a, b);
      end
      default: ;
    endcase
  endtask

  // Entered and left just after a falling edge.
  task automatic step();
    logic [31:0] npc, wd, ad, dq, wa, wv;
    logic wen, ce, we, wr;
    logic [4:0] rd;
    #1;
    m_eval(npc, wen, rd, wd, ce, we, ad, dq);
    chk("pc", inst_addr_o, m_pc);
    chk("ice", 32'(inst_ce_o), 32'd1);
    chk("dce", 32'(data_ce_o), 32'(ce));
    chk("dwe", 32'(data_we_o), 32'(we));
    chk("dadr", data_addr_o, ad);
    if (!(ce && !we)) chk("dout", data_o, dq);
    wr = data_we_o;
    wa = data_addr_o;
    wv = data_o;
    @(posedge clk);
    if (wr) dmem[wa[7:2]] = wv;
    m_pc = npc;
    if (wen && rd != 0) m_x[rd] = wd;
    if (we) m_dm[ad[7:2]] = dq;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_ice", 32'(inst_ce_o), 32'd0);
      chk("rst_dce", 32'(data_ce_o), 32'd0);
      chk("rst_dwe", 32'(data_we_o), 32'd0);
    end
    rst = 1'b0;
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
    #1;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 64; i++)
      imem[i] = (i < prog.size()) ? prog[i] : 32'd0;
  endtask

  function automatic logic [31:0] gen();
    logic [4:0] rd, r1, r2;
    logic [2:0] f3;
    int o;
    rd = 5'($urandom_range(0, 31));
    r1 = 5'($urandom_range(0, 31));
    r2 = 5'($urandom_range(0, 31));
    f3 = 3'($urandom_range(0, 7));
    o  = int'($urandom_range(0, 30)) - 15;
    case ($urandom_range(0, 11))
      0, 1: return e_r(($urandom_range(0, 3) == 0) ? 7'h20
                       : 7'h00, f3, rd, r1, r2);
      2, 3: begin
        if (f3 == 1 || f3 == 5)
          return e_i(7'h13, f3, rd, r1,
            {($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20,
             5'($urandom_range(0, 31))});
        return e_i(7'h13, f3, rd, r1, 12'($urandom()));
      end
      4: return {20'($urandom()), rd,
                 ($urandom_range(0, 1) == 0) ? 7'h37 : 7'h17};
      5: return e_b(f3, r1, r2, 13'(o * 4));
      6: return e_j(rd, 21'(o * 4));
      7: return e_i(7'h67, 3'd0, rd, r1,
                    12'($urandom_range(0, 255)));
      8: return e_i(7'h03, 3'd2, rd, r1, 12'($urandom()));
      9, 10: return e_s(r2, r1, 12'($urandom()));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic [31:0] saved;
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
    for (int i = 0; i < 64; i++) begin
      dmem[i] = 32'hA500_0000 | 32'(i);
      m_dm[i] = dmem[i];
    end

    // Arithmetic / compare program.
    prog = '{e_i(7'h13, 0, 1, 0, 12'd5),
             e_i(7'h13, 0, 2, 0, 12'hFFD),
             e_r(7'h00, 0, 3, 1, 2),
             e_r(7'h20, 0, 4, 1, 2),
             e_r(7'h00, 2, 5, 2, 1),
             e_r(7'h00, 3, 6, 2, 1),
             e_s(3, 0, 12'd0), e_s(4, 0, 12'd4),
             e_s(5, 0, 12'd8), e_s(6, 0, 12'd12)};
    load_prog();
    do_reset(3);
    chk("rel_pc", inst_addr_o, 32'd0);
    chk("rel_ice", 32'(inst_ce_o), 32'd1);
    repeat (10) step();
    chk("add", dmem[0], 32'd2);
    chk("sub", dmem[1], 32'd8);
    chk("slt", dmem[2], 32'd1);
    chk("sltu", dmem[3], 32'd0);

    // Store then load back.
    prog = '{e_i(7'h13, 0, 1, 0, 12'h055),
             e_s(1, 0, 12'd16),
             e_i(7'h03, 2, 2, 0, 12'd16),
             e_s(2, 0, 12'd20)};
    load_prog();
    do_reset(1);
    step();
    #1;
    chk("sw_we", 32'(data_we_o), 32'd1);
    chk("sw_adr", data_addr_o, 32'd16);
    chk("sw_dat", data_o, 32'h55);
    repeat (3) step();
    chk("sw_mem", dmem[4], 32'h55);
    chk("lw_x2", dmem[5], 32'h55);

    // Counted loop, then a not-taken BEQ.
    prog = '{e_i(7'h13, 0, 1, 0, 12'd1),
             e_i(7'h13, 0, 10, 0, 12'd10),
             e_i(7'h13, 0, 2, 2, 12'd1),
             e_b(3'd1, 2, 10, 13'h1FFC),
             e_b(3'd0, 2, 1, 13'd8),
             e_s(2, 0, 12'd24),
             e_s(1, 0, 12'd28)};
    load_prog();
    do_reset(1);
    repeat (24) step();
    chk("loop_pc", inst_addr_o, 32'd24);
    chk("loop_x2", dmem[6], 32'd10);

    // Jumps, LUI, x0 writes, all-zero NOP.
    prog = '{e_i(7'h13, 0, 0, 0, 12'd7),
             32'd0,
             {20'h12345, 5'd5, 7'h37},
             e_s(5, 0, 12'd32),
             e_s(0, 0, 12'd36),
             32'd0, 32'd0, 32'd0,
             e_j(1, 21'd8),
             e_s(1, 0, 12'd40),
             e_i(7'h67, 0, 0, 1, 12'd0)};
    load_prog();
    do_reset(1);
    repeat (9) step();
    chk("jal_pc", inst_addr_o, 32'h28);
    step();
    chk("jalr_pc", inst_addr_o, 32'h24);
    step();
    chk("lui", dmem[8], 32'h1234_5000);
    chk("x0", dmem[9], 32'd0);
    chk("jal_ra", dmem[10], 32'h24);

    // Random programs.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 64; i++) imem[i] = gen();
      do_reset(2);
      repeat (400) step();
    end

    // Reset landing on a store cycle.
    prog = '{e_i(7'h13, 0, 7, 0, 12'd99),
             e_s(7, 0, 12'd44)};
    load_prog();
    do_reset(1);
    step();
    saved = dmem[11];
    #1;
    chk("pre_we", 32'(data_we_o), 32'd1);
    rst = 1'b1;
    #1;
    chk("abt_we", 32'(data_we_o), 32'd0);
    chk("abt_ce", 32'(data_ce_o), 32'd0);
    prog.delete();
    for (int i = 1; i < 32; i++)
      prog.push_back(e_s(5'(i), 0, 12'(i * 4)));
    load_prog();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
    #1;
    chk("abt_pc", inst_addr_o, 32'd0);
    chk("abt_mem", dmem[11], saved);
    repeat (31) step();
    for (int i = 1; i < 32; i++) chk("reg0", dmem[i], 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/riscv.md
RISCV -- requirements
Module: riscv

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded by reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 inst_addr_o  output  32  byte address of current instruction (equals PC).
REQ-005 inst_i  input  32  instruction word, combinationally returned by instruction memory for inst_addr_o.
REQ-006 inst_ce_o  output  1  instruction fetch enable.
REQ-007 data_ce_o  output  1  data memory access enable, high only for LW/SW.
REQ-008 data_we_o  output  1  data memory write enable, high only for SW.
REQ-009 data_addr_o  output  32  byte address of load/store (rs1 + imm).
REQ-010 data_i  input  32  load data, combinationally returned for data_addr_o.
REQ-011 data_o  output  32  store data (rs2 value).

Function
REQ-012 Core SHALL be single-cycle: fetch, decode, execute, memory and writeback complete within one clk period; CPI = 1.
REQ-013 Supported RV32I subset: LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU, LW, SW, ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI, ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
REQ-014 Register file: 32 x 32-bit; two combinational read ports, one write port written on rising clk; x0 reads 0, writes to x0 discarded.
REQ-015 Read of a register written in the same cycle SHALL return the old value (write takes effect at the edge).
REQ-016 Immediates SHALL be sign-extended per RV32I I/S/B/U/J formats; shift amount = low 5 bits of imm or rs2.
REQ-017 Arithmetic is 32-bit modulo 2^32; overflow ignored; SLT/BLT/BGE signed, SLTU/BLTU/BGEU unsigned.
REQ-018 Next PC: branch taken -> PC + B-imm; JAL -> PC + J-imm; JALR -> (rs1 + imm) & ~1; otherwise PC + 4.
REQ-019 JAL/JALR SHALL write PC + 4 to rd.
REQ-020 LW writes data_i to rd in the same cycle; only word accesses supported, address assumed word-aligned (low 2 bits passed through unchanged).
REQ-021 SW: data_ce_o = 1, data_we_o = 1, data_o = rs2, data_addr_o = rs1 + S-imm; memory commits at the rising edge.
REQ-022 For non-memory instructions data_ce_o = 0, data_we_o = 0, data_addr_o and data_o = 0.
REQ-023 Unsupported/illegal opcode (including all-zero word) SHALL execute as NOP: no register write, no memory access, PC + 4.
REQ-024 Misaligned branch/jump targets are not trapped; PC takes computed value.

Reset
REQ-025 While rst = 1 at a rising edge: PC <= RESET_PC, all 32 registers <= 0.
REQ-026 While rst = 1: inst_ce_o = 0, data_ce_o = 0, data_we_o = 0, no register writes occur.
REQ-027 First instruction after rst deasserts SHALL be fetched from RESET_PC with inst_ce_o = 1.
REQ-028 Reset asserted mid-program SHALL abort the current instruction (no memory write, no register write) and restart at RESET_PC.

Verification
REQ-029 Reset held 3 cycles, released -> inst_addr_o = 0, inst_ce_o = 1; next cycles inst_addr_o = 4, 8, 12.
REQ-030 ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SUB x4,x1,x2 -> x3 = 2, x4 = 8; SLT x5,x2,x1 = 1; SLTU x6,x2,x1 = 0.
REQ-031 ADDI x1,x0,0x55; SW x1,16(x0); LW x2,16(x0) -> SW cycle shows data_we_o = 1, data_addr_o = 16, data_o = 0x55; x2 = 0x55.
REQ-032 x1 = 1 loop: ADDI x2,x2,1; BNE x2,x10(=10) back -4 -> exits with x2 = 10 after 10 iterations; BEQ not taken falls through to PC + 4.
REQ-033 JAL x1,+8 at PC 0x20 -> PC = 0x28, x1 = 0x24; JALR x0,0(x1) -> PC = 0x24; LUI x5,0x12345 -> x5 = 0x12345000; ADDI x0,x0,7 -> x0 stays 0.
REQ-034 Assert rst during a SW cycle -> no memory write, PC = 0 next cycle, all registers read 0.
